// File: rtl/ssd1306_seq_pkg.sv
// Shared definitions for the SSD1306 command sequencer: ROM word layout,
// local opcodes and the sequencer FSM states.
package ssd1306_pkg;

  localparam int WORD_W    = 10;
  localparam int BIT_LOCAL = 9;
  localparam int BIT_LAST  = 8;

  localparam logic [3:0] OP_SET_RESET  = 4'b0001;
  localparam logic [3:0] OP_SET_VBAT   = 4'b0010;
  localparam logic [3:0] OP_DELAY      = 4'b0011;
  localparam logic [3:0] OP_SET_DC     = 4'b0100;
  localparam logic [3:0] OP_LOOP_BEGIN = 4'b0101;
  localparam logic [3:0] OP_LOOP_END   = 4'b0110;
  localparam logic [3:0] OP_STOP       = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DELAY,
    ST_SEND,
    ST_WAIT,
    ST_NEXT
  } state_e;

  function automatic logic [3:0] word_op(input logic [WORD_W-1:0] w);
    return w[7:4];
  endfunction

  function automatic logic [3:0] word_arg(input logic [WORD_W-1:0] w);
    return w[3:0];
  endfunction

endpackage

// File: rtl/ssd1306_seq_if.sv
// ROM fetch port and byte-shifter handshake seen by the sequencer (master)
// and by the ROM/shifter side (slave).
interface ssd1306_seq_if #(
  parameter int ADDR_W = 6
);
  import ssd1306_pkg::*;

  logic [ADDR_W-1:0] rom_addr_out;
  logic [WORD_W-1:0] rom_data_in;
  logic              command_start;
  logic [7:0]        command_out;
  logic              command_last_byte;
  logic              command_ready;

  modport master (
    output rom_addr_out,
    output command_start,
    output command_out,
    output command_last_byte,
    input  rom_data_in,
    input  command_ready
  );

  modport slave (
    input  rom_addr_out,
    input  command_start,
    input  command_out,
    input  command_last_byte,
    output rom_data_in,
    output command_ready
  );

endinterface

// File: rtl/ssd1306_delay_timer.sv
// Down-counter for DELAY words: loads arg scaled by 2^DELAY_SHIFT and counts
// to zero while enabled.
module ssd1306_delay_timer
  import ssd1306_pkg::*;
#(
  parameter int DELAY_SHIFT = 13
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       load_in,
  input  logic [3:0] arg_in,
  input  logic       dec_in,
  output logic       zero_out
);

  localparam int CNT_W = 4 + DELAY_SHIFT;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      cnt_d = CNT_W'(arg_in) << DELAY_SHIFT;
    end else if (dec_in && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_out = (cnt_q == '0);

endmodule

// File: rtl/ssd1306_seq.sv
// ROM-driven SSD1306 command sequencer: fetches 10-bit words, executes local
// pin/delay/loop opcodes and hands transmit bytes to the SPI shifter.
module ssd1306_seq
  import ssd1306_pkg::*;
#(
  parameter int                        ADDR_W      = 6,
  parameter int                        NUM_SEQ     = 4,
  parameter logic [NUM_SEQ*ADDR_W-1:0] SEQ_BASE    = '0,
  parameter int                        DELAY_SHIFT = 13,
  parameter int                        SEL_W       = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
  input  logic             clk_in,
  input  logic             resetn_in,
  input  logic             start_in,
  input  logic [SEL_W-1:0] seq_sel_in,
  input  logic             abort_in,
  output logic             busy_out,
  output logic             done_out,
  ssd1306_seq_if.master    bus,
  output logic             oled_rstn,
  output logic             oled_vbatn,
  output logic             oled_dc
);

  // Reset asserts asynchronously but is released two clocks after resetn_in rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic [ADDR_W-1:0] base_tbl [NUM_SEQ];

  for (genvar gi = 0; gi < NUM_SEQ; gi++) begin : g_base
    assign base_tbl[gi] = SEQ_BASE[gi*ADDR_W +: ADDR_W];
  end

  logic [ADDR_W-1:0] sel_base;

  always_comb begin
    sel_base = '0;
    for (int i = 0; i < NUM_SEQ; i++) begin
      if (32'(seq_sel_in) == i) sel_base = base_tbl[i];
    end
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] loop_addr_q, loop_addr_d;
  logic [3:0]        loop_cnt_q, loop_cnt_d;
  logic              jump_q, jump_d;
  logic              done_q, done_d;
  logic              rstn_q, rstn_d;
  logic              vbatn_q, vbatn_d;
  logic              dc_q, dc_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  logic [WORD_W-1:0] word;
  logic [3:0]        op;
  logic [3:0]        arg;

  assign word = bus.rom_data_in;
  assign op   = word_op(word);
  assign arg  = word_arg(word);

  ssd1306_delay_timer #(
    .DELAY_SHIFT(DELAY_SHIFT)
  ) u_timer (
    .clk_in  (clk_in),
    .rst_n_in(rst_n),
    .load_in (tmr_load),
    .arg_in  (arg),
    .dec_in  (tmr_dec),
    .zero_out(tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    loop_addr_d = loop_addr_q;
    loop_cnt_d  = loop_cnt_q;
    jump_d      = jump_q;
    done_d      = 1'b0;
    rstn_d      = rstn_q;
    vbatn_d     = vbatn_q;
    dc_d        = dc_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    if (abort_in) begin
      state_d = ST_IDLE;
      jump_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            addr_d     = sel_base;
            loop_cnt_d = '0;
            jump_d     = 1'b0;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC: begin
          if (!word[BIT_LOCAL]) begin
            if (bus.command_ready) state_d = ST_SEND;
          end else begin
            state_d = ST_NEXT;
            case (op)
              OP_SET_RESET:  rstn_d  = arg[0];
              OP_SET_VBAT:   vbatn_d = arg[0];
              OP_SET_DC:     dc_d    = arg[0];
              OP_DELAY: begin
                tmr_load = 1'b1;
                state_d  = ST_DELAY;
              end
              OP_LOOP_BEGIN: begin
                loop_addr_d = addr_q + ADDR_W'(1);
                loop_cnt_d  = arg;
              end
              OP_LOOP_END: begin
                if (loop_cnt_q != 4'd0) begin
                  loop_cnt_d = loop_cnt_q - 4'd1;
                  jump_d     = 1'b1;
                end
              end
              OP_STOP: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
              default: ;
            endcase
          end
        end
        ST_DELAY: begin
          if (tmr_zero) state_d = ST_NEXT;
          else          tmr_dec = 1'b1;
        end
        ST_SEND: if (!bus.command_ready) state_d = ST_WAIT;
        ST_WAIT: if (bus.command_ready) state_d = ST_NEXT;
        ST_NEXT: begin
          addr_d  = jump_q ? loop_addr_q : addr_q + ADDR_W'(1);
          jump_d  = 1'b0;
          state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      loop_addr_q <= '0;
      loop_cnt_q  <= '0;
      jump_q      <= 1'b0;
      done_q      <= 1'b0;
      rstn_q      <= 1'b0;
      vbatn_q     <= 1'b1;
      dc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      loop_addr_q <= loop_addr_d;
      loop_cnt_q  <= loop_cnt_d;
      jump_q      <= jump_d;
      done_q      <= done_d;
      rstn_q      <= rstn_d;
      vbatn_q     <= vbatn_d;
      dc_q        <= dc_d;
    end
  end

  assign busy_out              = (state_q != ST_IDLE);
  assign done_out              = done_q;
  assign bus.rom_addr_out      = addr_q;
  assign bus.command_start     = (state_q == ST_SEND);
  assign bus.command_out       = word[7:0];
  assign bus.command_last_byte = word[BIT_LAST];
  assign oled_rstn             = rstn_q;
  assign oled_vbatn            = vbatn_q;
  assign oled_dc               = dc_q;

endmodule

// File: tb/tb_ssd1306_seq.sv
// Randomised bench for ssd1306_seq: a word-level interpreter of the ROM predicts
// sends, pin levels and busy time; a simple shifter model drives the handshake.
module tb_ssd1306_seq;
  import ssd1306_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int NUM_SEQ = 4;
  localparam int DSH     = 2;
  localparam int SEL_W   = 2;
  localparam logic [NUM_SEQ*ADDR_W-1:0] BASES = {6'd48, 6'd32, 6'd16, 6'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic             start;
  logic             abort_i;
  logic [SEL_W-1:0] sel;
  logic             busy, done, rstn_p, vbatn_p, dc_p;

  ssd1306_seq_if #(.ADDR_W(ADDR_W)) bus ();

  ssd1306_seq #(
    .ADDR_W     (ADDR_W),
    .NUM_SEQ    (NUM_SEQ),
    .SEQ_BASE   (BASES),
    .DELAY_SHIFT(DSH),
    .SEL_W      (SEL_W)
  ) dut (
    .clk_in    (clk),
    .resetn_in (resetn),
    .start_in  (start),
    .seq_sel_in(sel),
    .abort_in  (abort_i),
    .busy_out  (busy),
    .done_out  (done),
    .bus       (bus),
    .oled_rstn (rstn_p),
    .oled_vbatn(vbatn_p),
    .oled_dc   (dc_p)
  );

  // Synchronous ROM, one cycle read latency.
  logic [9:0] rom [64];
  logic [9:0] rom_q;
  always @(posedge clk) rom_q <= rom[bus.rom_addr_out];
  assign bus.rom_data_in = rom_q;

  // Shifter: accepts a byte when idle, then stays busy for lat cycles.
  int         lat;
  logic       rdy_q;
  int         scnt;
  logic [9:0] sent_q [$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_q <= 1'b1;
      scnt  <= 0;
    end else if (rdy_q && bus.command_start) begin
      sent_q.push_back({dc_p, bus.command_last_byte, bus.command_out});
      rdy_q <= 1'b0;
      scnt  <= lat - 1;
    end else if (!rdy_q) begin
      if (scnt == 0) rdy_q <= 1'b1;
      else           scnt  <= scnt - 1;
    end
  end
  assign bus.command_ready = rdy_q;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  logic       m_rstn, m_vbatn, m_dc;
  logic [9:0] exp_q [$];

  function automatic int base_of(input int s);
    return s * 16;
  endfunction

  // Word-level interpretation of a sequence; cycle cost per word as documented.
  task automatic model_run(input int s, output int cyc);
    int pc, pc_next, lcnt, laddr;
    logic [9:0] w;
    bit fin;
    pc = base_of(s); lcnt = 0; laddr = 0; cyc = 0; fin = 0;
    exp_q.delete();
    for (int step = 0; step < 1000 && !fin; step++) begin
      w = rom[pc];
      pc_next = (pc + 1) % 64;
      if (!w[9]) begin
        exp_q.push_back({m_dc, w[8], w[7:0]});
        cyc += 3;
      end else begin
        case (w[7:4])
          4'h1: begin m_rstn  = w[0]; cyc += 3; end
          4'h2: begin m_vbatn = w[0]; cyc += 3; end
          4'h3: cyc += int'(w[3:0]) * (1 << DSH) + 1 + 3;
          4'h4: begin m_dc    = w[0]; cyc += 3; end
          4'h5: begin laddr = pc_next; lcnt = int'(w[3:0]); cyc += 3; end
          4'h6: begin
            cyc += 3;
            if (lcnt != 0) begin lcnt--; pc_next = laddr; end
          end
          4'hF: begin cyc += 2; fin = 1; end
          default: cyc += 3;
        endcase
      end
      pc = pc_next;
    end
  endtask

  task automatic run_seq(input int s, input bit chk_cyc, input bit extra);
    int exp_cyc, cyc, busy_cnt, start_lo, addr_lo;
    bit got_done;
    logic [ADDR_W-1:0] prev_addr;
    model_run(s, exp_cyc);
    sent_q.delete();
    @(negedge clk); start = 1'b1; sel = SEL_W'(s);
    @(negedge clk); start = 1'b0;
    chk("fetch_addr", 32'(bus.rom_addr_out), 32'(base_of(s)));
    cyc = 0; busy_cnt = 0; start_lo = 0; addr_lo = 0; got_done = 0;
    prev_addr = bus.rom_addr_out;
    while (!got_done && cyc < 4000) begin
      start = 1'b0;
      if (done) begin
        got_done = 1;
        chk("busy_at_done", 32'(busy), 32'd0);
      end else begin
        if (busy) busy_cnt++;
        if (bus.command_start && !bus.command_ready) start_lo++;
        if (!bus.command_ready && bus.rom_addr_out != prev_addr) addr_lo++;
        prev_addr = bus.rom_addr_out;
        if (extra && cyc == 2 && busy) begin
          start = 1'b1;
          sel   = SEL_W'(s ^ 1);
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    if (chk_cyc) chk("busy_cycles", 32'(busy_cnt), 32'(exp_cyc));
    chk("n_sends", 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk($sformatf("send%0d{dc,last,byte}", i), 32'(sent_q[i]), 32'(exp_q[i]));
    chk("pin_rstn", 32'(rstn_p), 32'(m_rstn));
    chk("pin_vbatn", 32'(vbatn_p), 32'(m_vbatn));
    chk("pin_dc", 32'(dc_p), 32'(m_dc));
    chk("start_after_fall", 32'(start_lo <= exp_q.size()), 32'd1);
    chk("retire_while_busy", 32'(addr_lo), 32'd0);
    $display("seq %0d: %0d sends, %0d busy cycles, lat %0d", s, sent_q.size(), busy_cnt, lat);
  endtask

  function automatic logic [9:0] rand_word(input bit local_only);
    int k, r;
    k = local_only ? $urandom_range(0, 4) : $urandom_range(0, 6);
    case (k)
      0: return 10'h210 | 10'($urandom_range(0, 15));
      1: return 10'h220 | 10'($urandom_range(0, 15));
      2: return 10'h240 | 10'($urandom_range(0, 15));
      3: return 10'h230 | 10'($urandom_range(0, 3));
      4: begin
        r = $urandom_range(6, 14);
        if (r == 6) r = 0;
        return 10'h200 | 10'(r << 4) | 10'($urandom_range(0, 15));
      end
      default: return 10'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic gen_seq(input int s, input bit local_only);
    int a, n;
    a = base_of(s);
    if ($urandom_range(0, 3) == 0) begin rom[a] = 10'h260; a++; end
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin rom[a] = rand_word(local_only); a++; end
    if ($urandom_range(0, 1) == 1) begin
      rom[a] = 10'h250 | 10'($urandom_range(0, 2)); a++;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin rom[a] = rand_word(local_only); a++; end
      rom[a] = 10'h260; a++;
    end
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin rom[a] = rand_word(local_only); a++; end
    rom[a] = 10'h2F0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rstn"}, 32'(rstn_p), 32'd0);
    chk({pfx, "_vbatn"}, 32'(vbatn_p), 32'd1);
    chk({pfx, "_dc"}, 32'(dc_p), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_cmd_start"}, 32'(bus.command_start), 32'd0);
    chk({pfx, "_rom_addr"}, 32'(bus.rom_addr_out), 32'd0);
  endtask

  initial begin
    int dn, glitch, k;
    resetn = 1'b0; start = 1'b0; abort_i = 1'b0; sel = '0; lat = 3;
    m_rstn = 1'b0; m_vbatn = 1'b1; m_dc = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 10'h2F0;
    rom[0]  = 10'h211; rom[1]  = 10'h232; rom[2]  = 10'h1AF; rom[3]  = 10'h2F0;
    rom[16] = 10'h240; rom[17] = 10'h252; rom[18] = 10'h000; rom[19] = 10'h260;
    rom[20] = 10'h241; rom[21] = 10'h1A5; rom[22] = 10'h2F0;
    rom[32] = 10'h211; rom[33] = 10'h232; rom[34] = 10'h2F0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    run_seq(0, 1'b0, 1'b0);
    run_seq(2, 1'b1, 1'b0);
    lat = 20;
    run_seq(1, 1'b0, 1'b0);

    // Abort in the middle of the DELAY word of sequence 0.
    lat = 3;
    sent_q.delete();
    @(negedge clk); start = 1'b1; sel = 2'd0;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_pre_abort", 32'(busy), 32'd1);
    abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    dn = 0;
    repeat (20) begin @(negedge clk); if (done) dn++; end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_no_send", 32'(sent_q.size()), 32'd0);
    m_rstn = 1'b1;
    chk("abort_rstn", 32'(rstn_p), 32'(m_rstn));
    chk("abort_vbatn", 32'(vbatn_p), 32'(m_vbatn));
    run_seq(1, 1'b0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      lat = $urandom_range(1, 4);
      gen_seq(2 + (it % 2), (it % 3) != 1);
      run_seq(2 + (it % 2), (it % 3) != 1, (it % 2) == 0);
    end

    // Reset asserted while the first byte is being offered to the shifter.
    lat = 20;
    @(negedge clk); start = 1'b1; sel = 2'd0;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!bus.command_start && k < 100) begin @(negedge clk); k++; end
    chk("send_seen", 32'(bus.command_start), 32'd1);
    resetn = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    m_rstn = 1'b0; m_vbatn = 1'b1; m_dc = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    glitch = 0;
    repeat (12) begin @(negedge clk); if (bus.command_start || busy) glitch++; end
    chk("post_reset_glitch", 32'(glitch), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ssd1306_seq.md
# ssd1306_seq

Parametrised, ROM-driven command sequencer for the SSD1306 OLED path. It supersedes the single fixed power-up sequence with up to `NUM_SEQ` selectable sequences, such as init, display-off or power-down. It adds software-triggered start/abort, DC control, a scalable delay and one-level loops. It sits between an external synchronous sequence ROM and the byte shift-register (SPI) transmitter, and drives the panel reset, VBAT and DC pins directly.

## Interface
Parameters:
- `ADDR_W`, 6: ROM address width.
- `NUM_SEQ`, 4: number of selectable sequences.
- `SEQ_BASE`, 0: packed `NUM_SEQ*ADDR_W` vector; entry *i* is the start address of sequence *i*.
- `DELAY_SHIFT`, 13: delay unit is 2^`DELAY_SHIFT` cycles.
- `SEL_W`, `NUM_SEQ>1 ? $clog2(NUM_SEQ) : 1`: width of `seq_sel_in`.

Ports:
- `clk_in`  in  1  the single clock.
- `resetn_in`  in  1  async active-low reset; asynchronous assert, synchronous release.
- `start_in`  in  1  one-cycle request; accepted only in IDLE.
- `seq_sel_in`  in  `SEL_W`  sequence index, sampled with `start_in`.
- `abort_in`  in  1  return to IDLE from any state, without `done_out`.
- `busy_out`  out  1  high from start acceptance until return to IDLE.
- `done_out`  out  1  one-cycle pulse on STOP.
- `rom_addr_out`  out  `ADDR_W`  ROM address.
- `rom_data_in`  in  10  ROM word, valid 1 cycle after the address.
- `command_start`  out  1  send request to the shifter.
- `command_out`  out  8  byte to send.
- `command_last_byte`  out  1  CS framing flag to the shifter.
- `command_ready`  in  1  shifter idle.
- `oled_rstn`, `oled_vbatn`, `oled_dc`  out  1 each  panel pins.

## Operation
- ROM word layout:
  - bit 9 = local (1) or transmit (0).
  - bit 8 = last_byte.
  - bits 7:0 = payload.
  - For local words, bits 7:4 = opcode and bits 3:0 = argument.
- Local opcodes:
  - 0001 SET_RESET: `oled_rstn` = arg[0].
  - 0010 SET_VBAT: `oled_vbatn` = arg[0].
  - 0011 DELAY: wait arg×2^`DELAY_SHIFT` cycles.
  - 0100 SET_DC: `oled_dc` = arg[0].
  - 0101 LOOP_BEGIN: loop_addr = addr+1, loop_cnt = arg.
  - 0110 LOOP_END: if loop_cnt≠0, decrement it and jump to loop_addr; else fall through.
  - 1111 STOP.
  - Any other opcode is a NOP.
- Loop rules:
  - The loop body executes arg+1 times.
  - Single level only; a nested LOOP_BEGIN overwrites the loop state.
  - A LOOP_END with loop_cnt=0 and no active loop acts as a NOP.
- FSM states:
  - IDLE: on `start_in`, load the address from `SEQ_BASE[seq_sel_in]` (out-of-range index → 0), clear loop_cnt, set busy, go to FETCH.
  - FETCH: one cycle of ROM latency, then EXEC.
  - EXEC: decode the word. Transmit words go to SEND once `command_ready` is high; otherwise EXEC holds. DELAY loads the counter with {arg, `DELAY_SHIFT`'b0} and goes to DELAY. STOP goes to IDLE and pulses `done_out`. All other opcodes go to NEXT.
  - DELAY: decrement the counter; at 0, go to NEXT.
  - SEND: `command_start` high until `command_ready` falls, then WAIT.
  - WAIT: on `command_ready` high, go to NEXT.
  - NEXT: address ← address+1, or loop_addr on a taken LOOP_END; then FETCH.
- Address increment wraps modulo 2^`ADDR_W`. Every sequence must end in STOP.
- `abort_in` has priority over all transitions. It drops `command_start` and busy immediately and leaves the pin outputs unchanged.
- `start_in` outside IDLE is ignored.

## Timing
- Reset values:
  - `oled_rstn`=0, `oled_vbatn`=1, `oled_dc`=0.
  - `busy_out`=0, `done_out`=0, `command_start`=0, `rom_addr_out`=0.
  - Internal state: IDLE, counters 0.
- `command_out` and `command_last_byte` are combinational from `rom_data_in`. They are stable throughout SEND and WAIT.
- Per-word cost:
  - Local non-delay word: 3 cycles (FETCH, EXEC, NEXT).
  - DELAY with arg=n: n×2^`DELAY_SHIFT`+1 cycles in DELAY, plus 3 cycles overhead.
  - Transmit word: 3 cycles plus shifter time.
- Pin updates occur at the end of the EXEC cycle.
- `done_out` is asserted in the cycle after the STOP word is in EXEC. `busy_out` is low in that same cycle.
- A start request in the same cycle as `done_out` is accepted, because the FSM is already in IDLE.

## Structure
- `ssd1306_pkg`: opcode localparams, word bit positions, FSM state enum.
- Sub-module `ssd1306_delay_timer`: load/count/zero flag, parametrised by `DELAY_SHIFT`.

## Test plan
- Sequence 0 = [SET_RESET 1, DELAY 2, 0xAF last, STOP] with `DELAY_SHIFT`=2:
  - `oled_rstn` rises.
  - 9 cycles in DELAY.
  - One send of 0xAF with last=1.
  - `done_out` pulses once and `busy_out` falls.
- LOOP_BEGIN 2, send 0x00, LOOP_END, STOP: exactly 3 sends of 0x00.
- Shifter holds `command_ready` low for 20 cycles after start: `command_start` stays high until ready falls, and there is no retire until ready returns.
- `abort_in` mid-DELAY:
  - Next cycle: `busy_out`=0.
  - No `done_out`.
  - A new `start_in` with `seq_sel_in`=1 fetches from `SEQ_BASE[1]`.
- `resetn_in` asserted while SEND is active: all outputs take their reset values asynchronously, with no `command_start` glitch after release.
- `start_in` while busy is ignored. SET_DC 1 followed by a send shows `oled_dc`=1 during that send.
